mmix_mem_bridge: RTL
====================

Name: mmix_mem_bridge

Overview:
- Synthesizable responder for the CPU's mmix memory bus; the memory end of the protocol that the `cpu` block initiates.
- Accepts byte, wyde, tetra and octa reads and writes.
- Serialises each request into 16-bit accesses on the DE0 external SRAM using fixed wait states.
- Returns `mmix_done` for exactly one cycle. Replaces the simulation memory model in the FPGA top level.

Parameters:
- ADDR_W, 18, SRAM halfword address width.
- WAIT, 2, cycles per halfword slot; legal values are 2 to 15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- mmix_address  in  64  byte address from CPU
- mmix_datasize  in  2  0 = byte, 1 = wyde, 2 = tetra, 3 = octa
- mmix_read  in  1  read request, level
- mmix_readdata  out  64  read result, right-justified, zero-extended
- mmix_write  in  1  write request, level
- mmix_writedata  in  64  write data, right-justified
- mmix_done  out  1  one-cycle completion pulse
- busy  out  1  high from accept until the done cycle, inclusive
- sram_addr  out  ADDR_W  halfword address
- sram_wdata  out  16  write data
- sram_rdata  in  16  read data
- sram_ce, sram_oe, sram_we, sram_ub, sram_lb  out  1 each  active-high strobes; the top level inverts them for the pins

Behaviour:
- Reset values:
  - `mmix_readdata` = 0, `mmix_done` = 0, `busy` = 0.
  - All sram strobes = 0, `sram_addr` = 0, `sram_wdata` = 0.
  - State = IDLE.
- Reset asserted mid-transaction aborts it: strobes drop asynchronously and no done is issued.
- Accept: in IDLE, a clock edge with `mmix_read` or `mmix_write` high latches address, size, data and direction. If both are high, read wins and the write is ignored.
- Alignment follows MMIX rules:
  - Address low bits below the size are cleared: octa `A & ~7`, tetra `A & ~3`, wyde `A & ~1`.
  - Halfword index = aligned address bits `[ADDR_W:1]`; upper address bits are ignored, so addresses wrap modulo SRAM size.
- Slot count n: byte 1, wyde 1, tetra 2, octa 4.
- Halfwords are sequenced at ascending addresses and are big-endian: the first halfword is the most significant.
- States:
  - IDLE → ACCESS on accept.
  - ACCESS holds each slot for WAIT cycles and steps the address after each slot.
  - After slot n, ACCESS → DONE.
  - DONE lasts 1 cycle: `mmix_done` = 1, then → GAP.
  - GAP lasts 1 cycle with requests ignored, then → IDLE. This lets the CPU drop a held request.
- Latency: accept edge at cycle T; done high during cycle T + n·WAIT + 1; next accept possible at edge T + n·WAIT + 3.
- Read slot:
  - `sram_ce`, `sram_oe`, `sram_ub`, `sram_lb` all high for WAIT cycles.
  - `sram_rdata` is captured on the last edge of the slot and shifted into an accumulator.
  - Byte reads select bits `[15:8]` for an even address and `[7:0]` for an odd address.
  - Result is zero-extended into `mmix_readdata` and presented together with done.
  - `mmix_readdata` holds its value until the next read completes; writes leave it unchanged.
- Write slot:
  - `sram_ce` high for WAIT cycles; `sram_we` high for the first WAIT−1 cycles and low on the last cycle (address/data hold).
  - `sram_wdata` is stable for the whole slot.
  - Byte write: `sram_wdata` = {b,b}; only `sram_ub` is asserted for an even address, only `sram_lb` for an odd address.
  - Wyde, tetra and octa writes assert both byte enables; data is taken from `writedata[16·n−1:0]` MSB-first.
- `sram_oe` and `sram_we` are never high together.
- All strobes are low in IDLE, DONE and GAP.

Test Plan:
- Octa read: mem halfwords at 0x100..0x106 = 0x0123, 0x4567, 0x89AB, 0xCDEF; read size 3 at 0x105 → addresses 0x80..0x83 in order, `mmix_readdata` = 0x0123456789ABCDEF, done at T+9 (WAIT = 2).
- Byte read: halfword 0x80 = 0xA55A; read size 0 at 0x101 → `mmix_readdata` = 0x5A, a single slot, done at T+3.
- Byte write: write size 0, data 0x...77, at 0x100 → `sram_wdata` = 0x7777, ub = 1, lb = 0, `sram_we` high 1 cycle then low; readback of 0x100 returns 0x77.
- Tetra write with misaligned address: write size 2 at 0x10E, data 0xDEADBEEF → 0x86 ← 0xDEAD, 0x87 ← 0xBEEF; `mmix_readdata` is unchanged.
- Held request / simultaneous read and write: CPU keeps `mmix_read` high through GAP with read and write both high → exactly one read per done, each read completes, no write strobes ever occur.
- Reset at the second slot of an octa read → strobes 0 immediately, no done; after reset release a new byte read completes normally.

Source files
------------

// File: rtl/mmix_mem_bridge.sv
// -----------------------------------------------------------------------------
// mmix_mem_bridge
//
// Memory-side responder for the MMIX CPU bus. Each byte/wyde/tetra/octa
// request is broken into one, two or four 16-bit accesses on the external
// asynchronous SRAM. Every halfword access lasts a fixed WAIT cycles.
// Halfwords are visited at ascending addresses, most significant first.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   mmix_address      CPU byte address (upper bits beyond the SRAM wrap)
//   mmix_datasize     0 byte, 1 wyde, 2 tetra, 3 octa
//   mmix_read/_write  level requests; read wins when both are high
//   mmix_writedata    right-justified write data
//   mmix_readdata     right-justified, zero-extended read result
//   mmix_done         one-cycle completion pulse
//   busy              high from accept through the done cycle
//   sram_*            halfword address, data and active-high strobes
// -----------------------------------------------------------------------------
module mmix_mem_bridge #(
    parameter int ADDR_W = 18,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       mmix_address,
    input  logic [1:0]        mmix_datasize,
    input  logic              mmix_read,
    output logic [63:0]       mmix_readdata,
    input  logic              mmix_write,
    input  logic [63:0]       mmix_writedata,
    output logic              mmix_done,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              sram_ub,
    output logic              sram_lb
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_GAP
    } state_t;

    // Cycle index of the final cycle in a slot, and the cycle index after
    // which the write strobe is released so address/data get one hold cycle.
    localparam logic [3:0] LAST_CYC = 4'(WAIT - 1);
    localparam logic [3:0] WE_OFF   = 4'(WAIT - 2);

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;   // cycle position inside the current slot
    logic [1:0]  slot_reg;       // current slot number
    logic [1:0]  last_slot_reg;  // slot count minus one
    logic        is_read_reg;
    logic        is_byte_reg;
    logic        byte_odd_reg;   // selects the low byte lane for byte reads
    logic [47:0] acc_reg;        // halfwords read so far, oldest in the top
    logic [47:0] wbuf_reg;       // write halfwords still to send, next on top

    // Decode of the incoming request, used only on the accept edge.
    logic [2:0]        low_mask;
    logic [15:0]       first_hw;
    logic [47:0]       rest_hw;
    logic [1:0]        last_slot;
    logic [ADDR_W-1:0] start_index;
    logic              accept;
    logic              take_read;
    logic              byte_ub;
    logic              byte_lb;

    // Address bits above the SRAM are intentionally ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^mmix_address[63:ADDR_W+1];

    always_comb begin
        low_mask  = 3'd0;
        first_hw  = mmix_writedata[15:0];
        rest_hw   = 48'd0;
        last_slot = 2'd0;
        case (mmix_datasize)
            2'd0: begin
                // A byte is replicated on both lanes; the byte enables pick one.
                first_hw = {mmix_writedata[7:0], mmix_writedata[7:0]};
            end
            2'd1: begin
                low_mask = 3'd1;
            end
            2'd2: begin
                low_mask  = 3'd3;
                first_hw  = mmix_writedata[31:16];
                rest_hw   = {mmix_writedata[15:0], 32'd0};
                last_slot = 2'd1;
            end
            default: begin
                low_mask  = 3'd7;
                first_hw  = mmix_writedata[63:48];
                rest_hw   = mmix_writedata[47:0];
                last_slot = 2'd3;
            end
        endcase
    end

    // Halfword index of the aligned address; bit 0 of the byte address is
    // never part of it, so only mask bits [2:1] matter here.
    assign start_index = mmix_address[ADDR_W:1]
                       & ~{{(ADDR_W-2){1'b0}}, low_mask[2:1]};

    assign accept    = (state_reg == ST_IDLE) && (mmix_read || mmix_write);
    assign take_read = mmix_read;

    // Big-endian byte lanes: even byte address lives in the upper lane.
    assign byte_ub = ~mmix_address[0];
    assign byte_lb =  mmix_address[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 4'd0;
            slot_reg      <= 2'd0;
            last_slot_reg <= 2'd0;
            is_read_reg   <= 1'b0;
            is_byte_reg   <= 1'b0;
            byte_odd_reg  <= 1'b0;
            acc_reg       <= 48'd0;
            wbuf_reg      <= 48'd0;
            mmix_readdata <= 64'd0;
            mmix_done     <= 1'b0;
            busy          <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= 16'd0;
            sram_ce       <= 1'b0;
            sram_oe       <= 1'b0;
            sram_we       <= 1'b0;
            sram_ub       <= 1'b0;
            sram_lb       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= ST_ACCESS;
                        busy          <= 1'b1;
                        wait_cnt_reg  <= 4'd0;
                        slot_reg      <= 2'd0;
                        last_slot_reg <= last_slot;
                        is_read_reg   <= take_read;
                        is_byte_reg   <= (mmix_datasize == 2'd0);
                        byte_odd_reg  <= mmix_address[0];
                        acc_reg       <= 48'd0;
                        wbuf_reg      <= rest_hw;
                        sram_addr     <= start_index;
                        sram_wdata    <= first_hw;
                        sram_ce       <= 1'b1;
                        sram_oe       <= take_read;
                        sram_we       <= ~take_read;
                        // Only a byte write narrows the lanes.
                        if (!take_read && mmix_datasize == 2'd0) begin
                            sram_ub <= byte_ub;
                            sram_lb <= byte_lb;
                        end else begin
                            sram_ub <= 1'b1;
                            sram_lb <= 1'b1;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (wait_cnt_reg == LAST_CYC) begin
                        // End of a slot: read data has had the full slot to settle.
                        if (slot_reg == last_slot_reg) begin
                            state_reg <= ST_DONE;
                            mmix_done <= 1'b1;
                            sram_ce   <= 1'b0;
                            sram_oe   <= 1'b0;
                            sram_we   <= 1'b0;
                            sram_ub   <= 1'b0;
                            sram_lb   <= 1'b0;
                            if (is_read_reg) begin
                                if (is_byte_reg) begin
                                    mmix_readdata <= {56'd0, byte_odd_reg ? sram_rdata[7:0]
                                                                          : sram_rdata[15:8]};
                                end else begin
                                    // acc_reg starts at zero, so shorter reads
                                    // come out zero-extended.
                                    mmix_readdata <= {acc_reg, sram_rdata};
                                end
                            end
                        end else begin
                            slot_reg     <= slot_reg + 2'd1;
                            wait_cnt_reg <= 4'd0;
                            sram_addr    <= sram_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                            sram_wdata   <= wbuf_reg[47:32];
                            wbuf_reg     <= {wbuf_reg[31:0], 16'd0};
                            sram_we      <= ~is_read_reg;
                            if (is_read_reg) begin
                                acc_reg <= {acc_reg[31:0], sram_rdata};
                            end
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                        if (wait_cnt_reg == WE_OFF) begin
                            sram_we <= 1'b0;
                        end
                    end
                end

                ST_DONE: begin
                    mmix_done <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= ST_GAP;
                end

                // One dead cycle so a CPU holding its request can drop it.
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
